// File: rtl/count_seq_ctrl_if.sv
// Control/status bundle between the issuing logic, count_seq_ctrl and its 4-bit counter.
// The slave side is the sequencing controller; the master side is everything around it.
interface count_seq_ctrl_if #(
  parameter int PW = 4
);
  logic          start;
  logic          stop;
  logic          mode;
  logic [1:4]    period;
  logic [PW-1:0] prescale;
  logic [1:4]    cnt_q;
  logic          cnt_en;
  logic          cnt_clr;
  logic          busy;
  logic          done;

  modport master (
    output start, stop, mode, period, prescale, cnt_q,
    input  cnt_en, cnt_clr, busy, done
  );

  modport slave (
    input  start, stop, mode, period, prescale, cnt_q,
    output cnt_en, cnt_clr, busy, done
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// Interval timer sequencer wrapped around a 4-bit up-counter: one-shot or periodic,
// with a prescaler, emitting a one-cycle done pulse at each terminal count.
module count_seq_ctrl #(
  parameter int PW = 4
) (
  input logic                clk,
  input logic                cl,
  count_seq_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_l;
  logic [1:4]    per_l;
  logic          mode_l;
  logic          tick;
  logic          term;

  // >= rather than == so a counter knocked past N still terminates on the next tick
  always_comb begin
    tick = (state == RUN) && (pre_cnt == pre_l);
    term = tick && (bus.cnt_q >= per_l);
  end

  always_comb begin
    bus.busy    = 1'b0;
    bus.cnt_en  = 1'b0;
    bus.cnt_clr = 1'b0;
    bus.done    = 1'b0;
    case (state)
      CLEAR: begin
        bus.busy    = 1'b1;
        bus.cnt_clr = 1'b1;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (bus.stop) begin
          bus.cnt_clr = 1'b1;
        end else if (term) begin
          bus.cnt_clr = 1'b1;
          bus.done    = 1'b1;
        end else if (tick) begin
          bus.cnt_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cl) begin
      state   <= IDLE;
      pre_cnt <= '0;
      per_l   <= '0;
      pre_l   <= '0;
      mode_l  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            per_l   <= bus.period;
            pre_l   <= bus.prescale;
            mode_l  <= bus.mode;
            pre_cnt <= '0;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          state <= bus.stop ? IDLE : RUN;
        end
        RUN: begin
          if (bus.stop) begin
            state <= IDLE;
          end else if (term) begin
            pre_cnt <= '0;
            if (!mode_l) state <= IDLE;
          end else if (tick) begin
            pre_cnt <= '0;
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl with a behavioural 4-bit counter closing the loop.
module tb_count_seq_ctrl;

  logic       clk;
  logic       cl;
  logic [3:0] cnt;
  logic       frc;
  logic [3:0] frc_val;
  int         n_chk;
  int         n_err;

  count_seq_ctrl_if #(.PW(4)) ifc ();

  count_seq_ctrl #(.PW(4)) dut (
    .clk (clk),
    .cl  (cl),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: clear dominates enable; frc lets the bench disturb the value
  always @(posedge clk) begin
    if (cl)               cnt <= 4'd0;
    else if (frc)         cnt <= frc_val;
    else if (ifc.cnt_clr) cnt <= 4'd0;
    else if (ifc.cnt_en)  cnt <= cnt + 4'd1;
  end
  assign ifc.cnt_q = cnt;

  typedef struct {
    logic       start, stop, mode;
    logic [3:0] period, prescale;
    logic       busy, en, clr, done;
    logic [3:0] q;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic st, logic sp, logic md, logic [3:0] n, logic [3:0] p,
                              logic b, logic e, logic c, logic d, logic [3:0] q);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = md; v.period = n; v.prescale = p;
    v.busy = b; v.en = e; v.clr = c; v.done = d; v.q = q;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic outs(input string tag, input logic b, input logic e, input logic c, input logic d);
    chk({tag, " busy"},    {7'd0, ifc.busy},    {7'd0, b});
    chk({tag, " cnt_en"},  {7'd0, ifc.cnt_en},  {7'd0, e});
    chk({tag, " cnt_clr"}, {7'd0, ifc.cnt_clr}, {7'd0, c});
    chk({tag, " done"},    {7'd0, ifc.done},    {7'd0, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic sp, input logic md,
                        input logic [3:0] n, input logic [3:0] p);
    ifc.start = st; ifc.stop = sp; ifc.mode = md; ifc.period = n; ifc.prescale = p;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    frc = 1'b0; frc_val = 4'd0;
    set_in(0, 0, 0, 4'd0, 4'd0);
    cl = 1'b1;

    // start, stop, mode, N, P | busy, en, clr, done, q
    vecs[0]  = mk(1, 0, 0, 3, 0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 3, 0,  1, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 3, 0,  1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 3, 0,  1, 1, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 3, 0,  1, 1, 0, 0, 2);
    vecs[5]  = mk(0, 0, 0, 3, 0,  1, 0, 1, 1, 3);
    vecs[6]  = mk(0, 0, 0, 3, 0,  0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 3, 0,  0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 3, 0,  0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 3, 0,  0, 0, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, 3, 0,  0, 0, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 3, 0,  1, 0, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 3, 0,  0, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 1, 0, 0,  1, 0, 1, 0, 0);
    vecs[15] = mk(0, 0, 1, 0, 0,  1, 0, 1, 1, 0);
    vecs[16] = mk(0, 0, 1, 0, 0,  1, 0, 1, 1, 0);
    vecs[17] = mk(0, 0, 1, 0, 0,  1, 0, 1, 1, 0);
    vecs[18] = mk(0, 1, 1, 0, 0,  1, 0, 1, 0, 0);
    vecs[19] = mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);

    // Power-up reset
    step(); step();
    outs("reset", 0, 0, 0, 0);
    cl = 1'b0;
    step();

    // Table: one-shot N=3 P=0, start+stop in IDLE, stop in CLEAR, N=0 P=0 periodic
    for (int i = 0; i < 20; i++) begin
      set_in(vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].period, vecs[i].prescale);
      #1;
      outs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].en, vecs[i].clr, vecs[i].done);
      chk($sformatf("vec%0d cnt_q", i), {4'd0, cnt}, {4'd0, vecs[i].q});
      step();
    end
    set_in(0, 0, 0, 4'd0, 4'd0);
    step();

    // Periodic N=2 P=3: done at 13, 25, 37, 49; period change mid-run ignored
    set_in(1, 0, 1, 4'd2, 4'd3);
    step();
    ifc.start = 1'b0;
    for (int c = 1; c <= 49; c++) begin
      if (c == 20) ifc.period = 4'd7;
      #1;
      chk($sformatf("per c%0d done", c), {7'd0, ifc.done},
          {7'd0, (c >= 13) && ((c - 13) % 12 == 0)});
      step();
    end
    ifc.stop = 1'b1;
    #1;
    outs("per stop", 1, 0, 1, 0);
    step();
    ifc.stop = 1'b0;
    #1;
    outs("per idle", 0, 0, 0, 0);
    step();

    // Stop mid-interval: periodic N=9 P=1, stop at cycle 10
    set_in(1, 0, 1, 4'd9, 4'd1);
    step();
    ifc.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      #1;
      chk($sformatf("stp c%0d done", c), {7'd0, ifc.done}, 8'd0);
      step();
    end
    ifc.stop = 1'b1;
    #1;
    outs("stp c10", 1, 0, 1, 0);
    step();
    ifc.stop = 1'b0;
    #1;
    outs("stp c11", 0, 0, 0, 0);
    chk("stp c11 cnt_q", {4'd0, cnt}, 8'd0);
    step();

    // Stop coincident with term: periodic N=1 P=0, term would fall at cycle 3
    set_in(1, 0, 1, 4'd1, 4'd0);
    step();
    ifc.start = 1'b0;
    step(); step();
    ifc.stop = 1'b1;
    #1;
    outs("stpterm c3", 1, 0, 1, 0);
    step();
    ifc.stop = 1'b0;
    #1;
    outs("stpterm c4", 0, 0, 0, 0);
    step();

    // Start while busy ignored: one-shot N=3 P=1, done at 9
    set_in(1, 0, 0, 4'd3, 4'd1);
    step();
    set_in(0, 0, 0, 4'd3, 4'd1);
    for (int c = 1; c <= 9; c++) begin
      if (c == 3) set_in(1, 0, 1, 4'd15, 4'd0);
      if (c == 4) set_in(0, 0, 0, 4'd3, 4'd1);
      #1;
      chk($sformatf("busy c%0d done", c), {7'd0, ifc.done}, {7'd0, c == 9});
      step();
    end
    #1;
    outs("busy c10", 0, 0, 0, 0);
    step();

    // Robustness: one-shot N=4 P=2, counter forced to 12 -> term at tick cycle 7
    set_in(1, 0, 0, 4'd4, 4'd2);
    step();
    ifc.start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      frc = (c == 5);
      frc_val = 4'd12;
      #1;
      chk($sformatf("rob c%0d done", c), {7'd0, ifc.done}, 8'd0);
      step();
    end
    frc = 1'b0;
    #1;
    chk("rob c7 cnt_q", {4'd0, cnt}, 8'd12);
    outs("rob c7", 1, 0, 1, 1);
    step();
    #1;
    outs("rob c8", 0, 0, 0, 0);
    chk("rob c8 cnt_q", {4'd0, cnt}, 8'd0);
    step();

    // cl mid-run (periodic N=5 P=2) with a stray start held through it
    set_in(1, 0, 1, 4'd5, 4'd2);
    step();
    ifc.start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    #1;
    chk("rst c8 busy", {7'd0, ifc.busy}, 8'd1);
    cl = 1'b1;
    ifc.start = 1'b1;
    step();
    #1;
    outs("rst c9", 0, 0, 0, 0);
    step();
    cl = 1'b0;
    #1;
    outs("rst c10", 0, 0, 0, 0);
    step();
    set_in(0, 1, 0, 4'd0, 4'd0);
    #1;
    outs("rst c11", 1, 0, 1, 0);
    step();
    ifc.stop = 1'b0;
    #1;
    outs("rst c12", 0, 0, 0, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
